// File: rtl/execute_dp_pipe_pkg.sv
// Shared types and RV-M decode helpers for the execute datapath.
package execute_dp_pipe_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } rvga_muldiv_op_e;

  typedef enum logic [1:0] {
    EXE_IDLE = 2'd0,
    EXE_BUSY = 2'd1,
    EXE_FIX  = 2'd2
  } rvga_exe_state_e;

  function automatic logic md_signed_a(input rvga_muldiv_op_e op);
    case (op)
      MD_MULH, MD_MULHSU, MD_DIV, MD_REM: md_signed_a = 1'b1;
      default:                            md_signed_a = 1'b0;
    endcase
  endfunction

  function automatic logic md_signed_b(input rvga_muldiv_op_e op);
    case (op)
      MD_MULH, MD_DIV, MD_REM: md_signed_b = 1'b1;
      default:                 md_signed_b = 1'b0;
    endcase
  endfunction

  function automatic logic md_is_div(input rvga_muldiv_op_e op);
    case (op)
      MD_DIV, MD_DIVU, MD_REM, MD_REMU: md_is_div = 1'b1;
      default:                          md_is_div = 1'b0;
    endcase
  endfunction

  function automatic logic md_is_rem(input rvga_muldiv_op_e op);
    case (op)
      MD_REM, MD_REMU: md_is_rem = 1'b1;
      default:         md_is_rem = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/execute_dp_pipe_if.sv
// Decode-side and memory-side handshake bundle of the execute datapath.
interface execute_dp_pipe_if #(
  parameter int width_p   = 32,
  parameter int fwd_els_p = 2
);
  localparam int sel_width_lp = $clog2(fwd_els_p + 2);

  logic                           v_i;
  logic                           ready_o;
  logic                           muldiv_v_i;
  logic [sel_width_lp-1:0]        amux_sel_i;
  logic [sel_width_lp-1:0]        bmux_sel_i;
  logic [2:0]                     op_i;
  logic                           alu_alt_i;
  logic                           alu_add_override_v_i;
  logic [width_p-1:0]             pc_i;
  logic [width_p-1:0]             imm_i;
  logic [width_p-1:0]             rs1_data_i;
  logic [width_p-1:0]             rs2_data_i;
  logic [fwd_els_p*width_p-1:0]   fwd_data_i;
  logic                           v_o;
  logic                           ready_i;
  logic [width_p-1:0]             result_o;
  logic                           bru_result_o;

  modport master (
    output v_i, muldiv_v_i, amux_sel_i, bmux_sel_i, op_i, alu_alt_i, alu_add_override_v_i,
    output pc_i, imm_i, rs1_data_i, rs2_data_i, fwd_data_i, ready_i,
    input  ready_o, v_o, result_o, bru_result_o
  );

  modport slave (
    input  v_i, muldiv_v_i, amux_sel_i, bmux_sel_i, op_i, alu_alt_i, alu_add_override_v_i,
    input  pc_i, imm_i, rs1_data_i, rs2_data_i, fwd_data_i, ready_i,
    output ready_o, v_o, result_o, bru_result_o
  );
endinterface

// File: rtl/execute_dp_pipe_muldiv.sv
// Iterative RV-M engine: shift-add multiply / restoring divide on operand
// magnitudes, one bit per cycle, with sign fixup in a final FIX state.
module execute_dp_pipe_muldiv
  import execute_dp_pipe_pkg::*;
#(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               flush_i,
  input  logic               start_i,
  input  rvga_muldiv_op_e    op_i,
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  input  logic               hold_i,
  output rvga_exe_state_e    state_o,
  output logic               done_o,
  output logic [width_p-1:0] result_o
);
  localparam int cnt_width_lp = $clog2(width_p + 1);

  rvga_exe_state_e           r_state, w_state_nxt;
  rvga_muldiv_op_e           r_op;
  logic [cnt_width_lp-1:0]   r_cnt;
  logic [width_p-1:0]        r_hi, r_lo, r_b;
  logic                      r_neg;
  logic                      w_sa, w_sb;
  logic [width_p-1:0]        w_abs_a, w_abs_b, w_hi_nxt, w_lo_nxt, w_diff;
  logic [width_p:0]          w_sum, w_rem_sh;
  logic [2*width_p-1:0]      w_prod;

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= EXE_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state: BUSY runs until the counter hits 1, FIX waits out downstream stalls
  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = EXE_IDLE;
    end else begin
      case (r_state)
        EXE_IDLE: w_state_nxt = start_i ? EXE_BUSY : EXE_IDLE;
        EXE_BUSY: w_state_nxt = (r_cnt == cnt_width_lp'(1)) ? EXE_FIX : EXE_BUSY;
        EXE_FIX:  w_state_nxt = hold_i ? EXE_FIX : EXE_IDLE;
        default:  w_state_nxt = EXE_IDLE;
      endcase
    end
  end

  // Operand magnitudes and one iteration of the engine
  always_comb begin
    w_sa     = md_signed_a(op_i) & a_i[width_p-1];
    w_sb     = md_signed_b(op_i) & b_i[width_p-1];
    w_abs_a  = w_sa ? -a_i : a_i;
    w_abs_b  = w_sb ? -b_i : b_i;
    w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(width_p+1){1'b0}});
    w_rem_sh = {r_hi, r_lo[width_p-1]};
    w_diff   = w_rem_sh[width_p-1:0] - r_b;
    if (md_is_div(r_op)) begin
      if (w_rem_sh >= {1'b0, r_b}) begin
        w_hi_nxt = w_diff;
        w_lo_nxt = {r_lo[width_p-2:0], 1'b1};
      end else begin
        w_hi_nxt = w_rem_sh[width_p-1:0];
        w_lo_nxt = {r_lo[width_p-2:0], 1'b0};
      end
    end else begin
      w_hi_nxt = w_sum[width_p:1];
      w_lo_nxt = {w_sum[0], r_lo[width_p-1:1]};
    end
  end

  // Engine registers: multiply keeps {product_hi, multiplier}, divide keeps {remainder, quotient}
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cnt <= {cnt_width_lp{1'b0}};
      r_hi  <= {width_p{1'b0}};
      r_lo  <= {width_p{1'b0}};
      r_b   <= {width_p{1'b0}};
      r_neg <= 1'b0;
      r_op  <= MD_MUL;
    end else if (flush_i) begin
      r_cnt <= {cnt_width_lp{1'b0}};
    end else if ((r_state == EXE_IDLE) && start_i) begin
      r_cnt <= cnt_width_lp'(width_p);
      r_op  <= op_i;
      r_hi  <= {width_p{1'b0}};
      r_lo  <= md_is_div(op_i) ? w_abs_a : w_abs_b;
      r_b   <= md_is_div(op_i) ? w_abs_b : w_abs_a;
      r_neg <= md_is_rem(op_i) ? w_sa : (w_sa ^ w_sb);
    end else if (r_state == EXE_BUSY) begin
      r_cnt <= r_cnt - cnt_width_lp'(1);
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
    end
  end

  // Sign correction and half select
  always_comb begin
    w_prod = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
    case (r_op)
      MD_MUL:                        result_o = w_prod[width_p-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  result_o = w_prod[2*width_p-1:width_p];
      MD_DIV, MD_DIVU:               result_o = r_neg ? -r_lo : r_lo;
      MD_REM, MD_REMU:               result_o = r_neg ? -r_hi : r_hi;
      default:                       result_o = {width_p{1'b0}};
    endcase
  end

  assign state_o = r_state;
  assign done_o  = (r_state == EXE_FIX);

endmodule

// File: rtl/execute_dp_pipe.sv
// Execute stage: operand muxing, single-cycle ALU/BRU and an iterative RV-M unit
// feeding a one-entry valid/ready output register.
module execute_dp_pipe
  import execute_dp_pipe_pkg::*;
#(
  parameter int width_p   = 32,
  parameter int fwd_els_p = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  execute_dp_pipe_if.slave dp
);
  localparam int shamt_width_lp = $clog2(width_p);
  localparam logic [width_p-1:0] min_lp  = {1'b1, {(width_p-1){1'b0}}};
  localparam logic [width_p-1:0] ones_lp = {width_p{1'b1}};
  localparam logic [width_p-1:0] zero_lp = {width_p{1'b0}};

  logic [width_p-1:0]        w_src_a [fwd_els_p+2];
  logic [width_p-1:0]        w_src_b [fwd_els_p+2];
  logic [width_p-1:0]        w_a, w_b, w_alu, w_special_res, w_md_result;
  logic [shamt_width_lp-1:0] w_shamt;
  logic [2:0]                w_alu_op;
  logic                      w_alu_sub, w_bru, w_b_zero, w_ovf, w_md_special;
  logic                      w_ready, w_accept, w_md_start, w_md_hold, w_md_done, w_md_write;
  rvga_muldiv_op_e           w_md_op;
  rvga_exe_state_e           w_state;
  logic                      r_v_o, r_bru;
  logic [width_p-1:0]        r_result;

  // Operand muxes; out-of-range selects fall back to the register file
  always_comb begin
    w_src_a[0] = dp.rs1_data_i;
    w_src_a[1] = dp.pc_i;
    w_src_b[0] = dp.rs2_data_i;
    w_src_b[1] = dp.imm_i;
    for (int k = 0; k < fwd_els_p; k++) begin
      w_src_a[k+2] = dp.fwd_data_i[k*width_p +: width_p];
      w_src_b[k+2] = dp.fwd_data_i[k*width_p +: width_p];
    end
    if (int'(dp.amux_sel_i) < fwd_els_p + 2) w_a = w_src_a[dp.amux_sel_i];
    else                                     w_a = dp.rs1_data_i;
    if (int'(dp.bmux_sel_i) < fwd_els_p + 2) w_b = w_src_b[dp.bmux_sel_i];
    else                                     w_b = dp.rs2_data_i;
  end

  // ALU and branch compare
  always_comb begin
    w_alu_op  = dp.alu_add_override_v_i ? 3'd0 : dp.op_i;
    w_alu_sub = dp.alu_alt_i & ~dp.alu_add_override_v_i;
    w_shamt   = w_b[shamt_width_lp-1:0];
    case (w_alu_op)
      3'd0:    w_alu = w_alu_sub ? (w_a - w_b) : (w_a + w_b);
      3'd1:    w_alu = w_a << w_shamt;
      3'd2:    w_alu = {{(width_p-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      3'd3:    w_alu = {{(width_p-1){1'b0}}, (w_a < w_b)};
      3'd4:    w_alu = w_a ^ w_b;
      3'd5:    w_alu = w_alu_sub ? $unsigned($signed(w_a) >>> w_shamt) : (w_a >> w_shamt);
      3'd6:    w_alu = w_a | w_b;
      3'd7:    w_alu = w_a & w_b;
      default: w_alu = zero_lp;
    endcase
    case (dp.op_i)
      3'd0:    w_bru = (w_a == w_b);
      3'd1:    w_bru = (w_a != w_b);
      3'd4:    w_bru = ($signed(w_a) < $signed(w_b));
      3'd5:    w_bru = ($signed(w_a) >= $signed(w_b));
      3'd6:    w_bru = (w_a < w_b);
      3'd7:    w_bru = (w_a >= w_b);
      default: w_bru = 1'b0;
    endcase
  end

  // Divides by zero and MIN/-1 bypass the iterative engine
  always_comb begin
    w_md_op      = rvga_muldiv_op_e'(dp.op_i);
    w_b_zero     = (w_b == zero_lp);
    w_ovf        = md_is_div(w_md_op) & md_signed_a(w_md_op) & (w_a == min_lp) & (w_b == ones_lp);
    w_md_special = md_is_div(w_md_op) & (w_b_zero | w_ovf);
    case (w_md_op)
      MD_DIV, MD_DIVU: w_special_res = w_b_zero ? ones_lp : min_lp;
      MD_REM, MD_REMU: w_special_res = w_b_zero ? w_a : zero_lp;
      default:         w_special_res = zero_lp;
    endcase
  end

  assign w_ready    = ~reset_i & (w_state == EXE_IDLE) & (~r_v_o | dp.ready_i);
  assign w_accept   = dp.v_i & w_ready & ~flush_i;
  assign w_md_start = w_accept & dp.muldiv_v_i & ~w_md_special;
  assign w_md_hold  = r_v_o & ~dp.ready_i;
  assign w_md_write = w_md_done & ~w_md_hold;

  execute_dp_pipe_muldiv #(.width_p(width_p)) u_muldiv (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .flush_i  (flush_i),
    .start_i  (w_md_start),
    .op_i     (w_md_op),
    .a_i      (w_a),
    .b_i      (w_b),
    .hold_i   (w_md_hold),
    .state_o  (w_state),
    .done_o   (w_md_done),
    .result_o (w_md_result)
  );

  // Output register: flush beats any write, a write beats the downstream pop
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_v_o    <= 1'b0;
      r_result <= zero_lp;
      r_bru    <= 1'b0;
    end else if (flush_i) begin
      r_v_o    <= 1'b0;
    end else if (w_accept && !w_md_start) begin
      r_v_o    <= 1'b1;
      r_result <= dp.muldiv_v_i ? w_special_res : w_alu;
      r_bru    <= dp.muldiv_v_i ? 1'b0 : w_bru;
    end else if (w_md_write) begin
      r_v_o    <= 1'b1;
      r_result <= w_md_result;
      r_bru    <= 1'b0;
    end else if (dp.ready_i) begin
      r_v_o    <= 1'b0;
    end
  end

  assign dp.ready_o      = w_ready;
  assign dp.v_o          = r_v_o;
  assign dp.result_o     = r_result;
  assign dp.bru_result_o = r_bru;

endmodule

// File: tb/tb_execute_dp_pipe.sv
// Directed bench for execute_dp_pipe: ALU, forwarding, RV-M latency, divide
// corner cases, back-pressure, flush and mid-operation reset.
module tb_execute_dp_pipe;
  localparam int W = 32;
  localparam int F = 2;

  logic clk_i = 1'b0;
  logic reset_i;
  logic flush_i;
  int   checks = 0;
  int   errors = 0;
  int   lat;
  logic rdy_seen;

  execute_dp_pipe_if #(.width_p(W), .fwd_els_p(F)) dp_if ();

  execute_dp_pipe #(.width_p(W), .fwd_els_p(F)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .flush_i (flush_i),
    .dp      (dp_if)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic md, input logic [2:0] op, input logic alt, input logic ovr,
                       input logic [1:0] asel, input logic [1:0] bsel,
                       input logic [W-1:0] rs1, input logic [W-1:0] rs2, input logic [W-1:0] imm);
    dp_if.v_i                  = 1'b1;
    dp_if.muldiv_v_i           = md;
    dp_if.op_i                 = op;
    dp_if.alu_alt_i            = alt;
    dp_if.alu_add_override_v_i = ovr;
    dp_if.amux_sel_i           = asel;
    dp_if.bmux_sel_i           = bsel;
    dp_if.rs1_data_i           = rs1;
    dp_if.rs2_data_i           = rs2;
    dp_if.imm_i                = imm;
  endtask

  task automatic issue(input logic md, input logic [2:0] op, input logic alt, input logic ovr,
                       input logic [1:0] asel, input logic [1:0] bsel,
                       input logic [W-1:0] rs1, input logic [W-1:0] rs2, input logic [W-1:0] imm);
    drive(md, op, alt, ovr, asel, bsel, rs1, rs2, imm);
    step();
    dp_if.v_i = 1'b0;
  endtask

  // Called in the cycle after accept; lat is the cycle count at which v_o is seen
  task automatic wait_vo(output int l, output logic rs);
    l  = 1;
    rs = 1'b0;
    while (dp_if.v_o !== 1'b1 && l < 60) begin
      if (dp_if.ready_o !== 1'b0) rs = 1'b1;
      step();
      l++;
    end
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (dp_if.v_o !== 1'b0) seen = 1'b1;
      step();
    end
    check1(tag, seen, 1'b0);
  endtask

  initial begin
    reset_i = 1'b1;
    flush_i = 1'b0;
    dp_if.v_i = 1'b0;
    dp_if.muldiv_v_i = 1'b0;
    dp_if.op_i = 3'd0;
    dp_if.alu_alt_i = 1'b0;
    dp_if.alu_add_override_v_i = 1'b0;
    dp_if.amux_sel_i = 2'd0;
    dp_if.bmux_sel_i = 2'd0;
    dp_if.pc_i = 32'h0000_1000;
    dp_if.imm_i = 32'd0;
    dp_if.rs1_data_i = 32'd0;
    dp_if.rs2_data_i = 32'd0;
    dp_if.fwd_data_i = {32'h0000_0010, 32'h0000_0003};
    dp_if.ready_i = 1'b1;

    // Reset state
    step();
    step();
    check1("rst_v_o", dp_if.v_o, 1'b0);
    check("rst_result", dp_if.result_o, 32'd0);
    check1("rst_bru", dp_if.bru_result_o, 1'b0);
    check1("rst_ready", dp_if.ready_o, 1'b0);
    reset_i = 1'b0;
    #1;
    check1("post_rst_ready", dp_if.ready_o, 1'b1);

    // ADD rs1 + imm
    issue(1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd1, 32'd5, 32'd99, 32'd7);
    check1("add_v_o", dp_if.v_o, 1'b1);
    check("add_result", dp_if.result_o, 32'd12);
    check1("add_bru", dp_if.bru_result_o, 1'b0);
    step();
    check1("add_popped", dp_if.v_o, 1'b0);

    // SUB on two forwarding slices
    issue(1'b0, 3'd0, 1'b1, 1'b0, 2'd3, 2'd2, 32'd0, 32'd0, 32'd0);
    check("fwd_sub", dp_if.result_o, 32'h0000_000D);

    // XOR result with BLT branch compare
    issue(1'b0, 3'd4, 1'b0, 1'b0, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    check("xor_result", dp_if.result_o, 32'hFFFF_FFFE);
    check1("blt_taken", dp_if.bru_result_o, 1'b1);

    // SRA, back-to-back with the next op
    issue(1'b0, 3'd5, 1'b1, 1'b0, 2'd0, 2'd0, 32'h8000_0000, 32'd4, 32'd0);
    check("sra_result", dp_if.result_o, 32'hF800_0000);
    check1("bge_not_taken", dp_if.bru_result_o, 1'b0);

    // ADD override on an SRA encoding
    issue(1'b0, 3'd5, 1'b1, 1'b1, 2'd0, 2'd0, 32'd3, 32'd4, 32'd0);
    check("override_add", dp_if.result_o, 32'd7);

    // MULH -1 x 2
    issue(1'b1, 3'd1, 1'b0, 1'b0, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'd2, 32'd0);
    wait_vo(lat, rdy_seen);
    check("mulh_latency", W'(lat), 32'd34);
    check1("mulh_ready_low", rdy_seen, 1'b0);
    check("mulh_result", dp_if.result_o, 32'hFFFF_FFFF);
    check1("mulh_bru", dp_if.bru_result_o, 1'b0);

    // MUL low half
    issue(1'b1, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'd2, 32'd0);
    wait_vo(lat, rdy_seen);
    check("mul_latency", W'(lat), 32'd34);
    check1("mul_ready_low", rdy_seen, 1'b0);
    check("mul_result", dp_if.result_o, 32'hFFFF_FFFE);

    // Special divides, one cycle each
    issue(1'b1, 3'd4, 1'b0, 1'b0, 2'd0, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    check1("div_ovf_v_o", dp_if.v_o, 1'b1);
    check("div_ovf_result", dp_if.result_o, 32'h8000_0000);
    check1("div_ovf_bru", dp_if.bru_result_o, 1'b0);
    issue(1'b1, 3'd6, 1'b0, 1'b0, 2'd0, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    check1("rem_ovf_v_o", dp_if.v_o, 1'b1);
    check("rem_ovf_result", dp_if.result_o, 32'd0);
    issue(1'b1, 3'd5, 1'b0, 1'b0, 2'd0, 2'd0, 32'd7, 32'd0, 32'd0);
    check1("divu0_v_o", dp_if.v_o, 1'b1);
    check("divu0_result", dp_if.result_o, 32'hFFFF_FFFF);
    issue(1'b1, 3'd7, 1'b0, 1'b0, 2'd0, 2'd0, 32'd7, 32'd0, 32'd0);
    check("remu0_result", dp_if.result_o, 32'd7);

    // Signed divide and remainder through the engine
    issue(1'b1, 3'd4, 1'b0, 1'b0, 2'd0, 2'd0, 32'hFFFF_FFF9, 32'd2, 32'd0);
    wait_vo(lat, rdy_seen);
    check("div_latency", W'(lat), 32'd34);
    check("div_result", dp_if.result_o, 32'hFFFF_FFFD);
    issue(1'b1, 3'd6, 1'b0, 1'b0, 2'd0, 2'd0, 32'hFFFF_FFF9, 32'd2, 32'd0);
    wait_vo(lat, rdy_seen);
    check("rem_result", dp_if.result_o, 32'hFFFF_FFFF);
    issue(1'b1, 3'd7, 1'b0, 1'b0, 2'd0, 2'd0, 32'd100, 32'd7, 32'd0);
    wait_vo(lat, rdy_seen);
    check("remu_result", dp_if.result_o, 32'd2);
    step();

    // Back-pressure on a held ALU result with an op waiting
    dp_if.ready_i = 1'b0;
    issue(1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd1, 32'h0000_1234, 32'd0, 32'd1);
    check("bp_alu_result", dp_if.result_o, 32'h0000_1235);
    drive(1'b1, 3'd5, 1'b0, 1'b0, 2'd0, 2'd0, 32'd7, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check1("bp_hold_ready", dp_if.ready_o, 1'b0);
      check1("bp_hold_v_o", dp_if.v_o, 1'b1);
      check("bp_hold_result", dp_if.result_o, 32'h0000_1235);
      step();
    end
    dp_if.ready_i = 1'b1;
    #1;
    check1("bp_ready_up", dp_if.ready_o, 1'b1);
    step();
    dp_if.v_i = 1'b0;
    check("bp_divu0_result", dp_if.result_o, 32'hFFFF_FFFF);

    // M result held under back-pressure
    issue(1'b1, 3'd3, 1'b0, 1'b0, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    dp_if.ready_i = 1'b0;
    wait_vo(lat, rdy_seen);
    check("mulhu_latency", W'(lat), 32'd34);
    check("mulhu_result", dp_if.result_o, 32'hFFFF_FFFE);
    step();
    step();
    check1("mulhu_held_v_o", dp_if.v_o, 1'b1);
    check("mulhu_held_result", dp_if.result_o, 32'hFFFF_FFFE);
    check1("mulhu_held_ready", dp_if.ready_o, 1'b0);
    dp_if.ready_i = 1'b1;
    step();
    check1("mulhu_popped", dp_if.v_o, 1'b0);
    check1("mulhu_ready_back", dp_if.ready_o, 1'b1);

    // Flush at BUSY cycle 10 of a DIVU
    issue(1'b1, 3'd5, 1'b0, 1'b0, 2'd0, 2'd0, 32'd100, 32'd7, 32'd0);
    for (int i = 0; i < 9; i++) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check1("flush_v_o", dp_if.v_o, 1'b0);
    check1("flush_ready", dp_if.ready_o, 1'b1);
    expect_quiet("flush_no_result", 40);
    issue(1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd1, 32'd2, 32'd0, 32'd3);
    check1("post_flush_v_o", dp_if.v_o, 1'b1);
    check("post_flush_add", dp_if.result_o, 32'd5);

    // Flush drops a held result
    dp_if.ready_i = 1'b0;
    step();
    check1("held_before_flush", dp_if.v_o, 1'b1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check1("flush_drops_held", dp_if.v_o, 1'b0);
    dp_if.ready_i = 1'b1;

    // Flush drops a same-cycle accept
    drive(1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd1, 32'd9, 32'd0, 32'd9);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    dp_if.v_i = 1'b0;
    check1("flush_drops_accept", dp_if.v_o, 1'b0);

    // Reset mid-BUSY
    issue(1'b1, 3'd5, 1'b0, 1'b0, 2'd0, 2'd0, 32'd100, 32'd7, 32'd0);
    for (int i = 0; i < 5; i++) step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    #1;
    check1("midrst_v_o", dp_if.v_o, 1'b0);
    check("midrst_result", dp_if.result_o, 32'd0);
    check1("midrst_ready", dp_if.ready_o, 1'b1);
    expect_quiet("midrst_no_result", 40);
    issue(1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd1, 32'd4, 32'd0, 32'd4);
    check1("post_rst_v_o", dp_if.v_o, 1'b1);
    check("post_rst_add", dp_if.result_o, 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

endmodule
